fetch_addr_gen: RTL and testbench
=================================

Name: fetch_addr_gen

Overview:
Fetch address generator that sits directly upstream of the return address stack. Each cycle it selects the next instruction-fetch word address from four sources, in priority order: boot, flush/redirect, RAS prediction, sequential. It drives an AHB-Lite-style instruction request. It also tells the RAS which address, alignment and validity the data returned in the next cycle carries. Predicted redirects kill the wrong-path request already in flight.

Parameters:
BOOT_ADDR, 32'h0000_0080, byte address of the first fetch after reset; bit 0 must be 0.
IFB_STALL_EN, 1, 1 = honour s_ifb_full_i backpressure; 0 = tie it off internally.

Ports:
s_clk_i  in  1  clock
s_resetn_i  in  1  reset; synchronous, active-low
s_flush_i  in  1  pipeline redirect request (branch mispredict, trap, fence)
s_flush_addr_i  in  31  halfword address of the redirect target ([30:0] = byte address [31:1])
s_ras_poped_i  in  2  RAS prediction taken from the data delivered this cycle
s_ras_addr_i  in  31  RAS predicted halfword target
s_ifb_full_i  in  1  instruction fetch buffer cannot accept a new beat
s_hready_i  in  1  bus ready
s_hresp_i  in  1  bus error response for the current data phase
s_haddr_o  out  32  bus address, word aligned ([1:0] = 0)
s_htrans_o  out  2  2'b10 NONSEQ or 2'b00 IDLE
s_fetch_addr_o  out  30  word address of the data valid in the next cycle (to RAS s_fetch_addr_i)
s_valid_o  out  1  fetched data valid in the next cycle (to RAS s_valid_i)
s_ualign_o  out  1  next data beat starts at halfword 1 (to RAS s_ualign_i)
s_ferr_o  out  1  data beat delivered this cycle carried a bus error

Behaviour:
- Reset (s_resetn_i=0 at a clock edge): state=BOOT, pc=BOOT_ADDR[31:2], htrans=IDLE, s_valid_o=0, s_ualign_o=0, s_ferr_o=0, s_fetch_addr_o=0, data-phase registers cleared. Reset overrides all inputs, including mid-transfer.
- States:
  - BOOT: for 1 cycle, issue NONSEQ at pc; go to RUN.
  - RUN: issue NONSEQ every cycle while s_hready_i=1 and there is no stall.
  - STALL: entered when s_ifb_full_i=1 with s_hready_i=1. htrans=IDLE, pc held. Return to RUN when s_ifb_full_i=0 (the issue happens in the same cycle).
  - HALT: optional; see Optional Feature.
- Address phase is accepted when s_hready_i=1 and htrans=NONSEQ. The accepted address moves to the data-phase register together with its ualign bit and a live bit.
- s_fetch_addr_o and s_valid_o reflect the data-phase register: s_valid_o = live and s_hready_i.
- Next-pc priority on an accepted cycle:
  - s_flush_i: pc = s_flush_addr_i[30:1], ualign_next = s_flush_addr_i[0].
  - else s_ras_poped_i != 0: pc = s_ras_addr_i[30:1], ualign_next = s_ras_addr_i[0].
  - else pc+1, ualign_next = 0.
- Flush and prediction take effect for the address issued in the same cycle (combinational bypass into s_haddr_o). Flush also works in STALL; the stall condition is re-evaluated on the next cycle.
- Kill rule: on flush or pop, the request currently in data phase is marked not live, so s_valid_o=0 for it. Flush also clears live on a beat that is held by s_hready_i=0.
- Wait states: s_hready_i=0 holds s_haddr_o/s_htrans_o stable. A redirect during a wait is registered as pending (flush overwrites an earlier pending pop). The pending redirect is applied as soon as s_hready_i=1.
- s_ualign_o: set only for the first beat after a redirect to an odd halfword; 0 for all other beats.
- pc wraps from 30'h3FFF_FFFF to 0 with no flag.
- s_ferr_o = live and s_hready_i and s_hresp_i.

Optional Feature:
Macro: OPTION_FETCH_ERR_HALT_EN.
- With the macro defined: a live beat with a bus error moves the block to HALT. In HALT, htrans=IDLE and s_valid_o=0 until s_flush_i=1; that flush redirects and returns the block to RUN.
- Without the macro: errors only assert s_ferr_o, and fetching continues sequentially.

Test Plan:
- Reset release, s_hready_i=1: first s_haddr_o=32'h80 NONSEQ, then 32'h84 and 32'h88. s_valid_o=1 from the cycle after the first issue; s_fetch_addr_o=30'h20, 30'h21, ...
- s_flush_i=1 with s_flush_addr_i=31'h0000_0101 while 32'h90 is in data phase: s_haddr_o=32'h200 in the same cycle. The 32'h90 beat has s_valid_o=0, and the 32'h200 beat has s_ualign_o=1. The following beat, 32'h204, has s_ualign_o=0.
- s_ras_poped_i=2'b01 with s_ras_addr_i=31'h0000_0400 and s_flush_i=0: next issue is 32'h800, and the wrong-path beat has s_valid_o=0. Repeat with flush and pop together: the flush target wins.
- s_ifb_full_i=1 for 3 cycles: htrans=IDLE for 3 cycles with pc held, then NONSEQ resumes at the held pc with no address skipped.
- s_hready_i=0 for 2 cycles with a pop arriving in the first cycle: the bus address is held stable, and the pop target is issued on the first s_hready_i=1 cycle.
- s_hresp_i=1 on a live beat: s_ferr_o=1. With OPTION_FETCH_ERR_HALT_EN, htrans stays IDLE until the next flush; without it, the next sequential address is issued.

Source files
------------

// File: rtl/fetch_addr_gen.sv
// Fetch address generator feeding the bus and the return address stack.
// Optional halt-on-bus-error behaviour is enabled by defining OPTION_FETCH_ERR_HALT_EN.
module fetch_addr_gen #(
    parameter logic [31:0] BOOT_ADDR    = 32'h0000_0080,
    parameter bit          IFB_STALL_EN = 1'b1
) (
    input  logic        s_clk_i,
    input  logic        s_resetn_i,
    input  logic        s_flush_i,
    input  logic [30:0] s_flush_addr_i,
    input  logic [1:0]  s_ras_poped_i,
    input  logic [30:0] s_ras_addr_i,
    input  logic        s_ifb_full_i,
    input  logic        s_hready_i,
    input  logic        s_hresp_i,
    output logic [31:0] s_haddr_o,
    output logic [1:0]  s_htrans_o,
    output logic [29:0] s_fetch_addr_o,
    output logic        s_valid_o,
    output logic        s_ualign_o,
    output logic        s_ferr_o
);

    typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_STALL, ST_HALT} state_e;

    state_e      state_q, state_d;
    logic [29:0] pc_q, pc_d;
    logic [29:0] dp_addr_q, dp_addr_d;
    logic        dp_ualign_q, dp_ualign_d;
    logic        dp_live_q, dp_live_d;
    logic        pend_vld_q, pend_vld_d;
    logic        pend_flush_q, pend_flush_d;
    logic [30:0] pend_addr_q, pend_addr_d;

    logic        ifb_full, flush, pop, live, err, halt_now;
    logic        issue_ok, issue, accept;
    logic [30:0] tgt;

    assign ifb_full = IFB_STALL_EN ? s_ifb_full_i : 1'b0;
    assign flush    = s_flush_i & (state_q != ST_BOOT);
    assign pop      = (|s_ras_poped_i) & ((state_q == ST_RUN) || (state_q == ST_STALL));
    // A redirect makes the beat currently in data phase wrong-path.
    assign live     = dp_live_q & ~flush & ~pop;
    assign err      = live & s_hready_i & s_hresp_i;

`ifdef OPTION_FETCH_ERR_HALT_EN
    assign halt_now = err;
`else
    assign halt_now = 1'b0;
`endif

    // Halfword issue address; redirects bypass only when the bus can take it,
    // so the address stays stable through wait states.
    always_comb begin
        tgt = {pc_q, (state_q == ST_BOOT) ? BOOT_ADDR[1] : 1'b0};
        if (s_hready_i) begin
            if (flush)           tgt = s_flush_addr_i;
            else if (pend_vld_q) tgt = pend_addr_q;
            else if (pop)        tgt = s_ras_addr_i;
        end
    end

    always_comb begin
        issue_ok = 1'b0;
        state_d  = state_q;
        case (state_q)
            ST_BOOT: begin
                issue_ok = 1'b1;
                state_d  = ST_RUN;
            end
            ST_RUN: begin
                issue_ok = ~(s_hready_i & ifb_full & ~flush);
                if (halt_now)                             state_d = ST_HALT;
                else if (s_hready_i & ifb_full & ~flush)  state_d = ST_STALL;
            end
            ST_STALL: begin
                issue_ok = ~ifb_full | flush;
                if (halt_now)               state_d = ST_HALT;
                else if (~ifb_full | flush) state_d = ST_RUN;
            end
            ST_HALT: begin
                issue_ok = flush;
                if (flush) state_d = ST_RUN;
            end
            default: state_d = ST_BOOT;
        endcase
    end

    assign issue  = s_resetn_i & issue_ok & ~halt_now;
    assign accept = issue & s_hready_i;

    always_comb begin
        pc_d         = pc_q;
        dp_addr_d    = dp_addr_q;
        dp_ualign_d  = dp_ualign_q;
        dp_live_d    = dp_live_q;
        pend_vld_d   = pend_vld_q;
        pend_flush_d = pend_flush_q;
        pend_addr_d  = pend_addr_q;

        if (accept) pc_d = tgt[30:1] + 30'd1;

        if (s_hready_i) begin
            dp_live_d   = accept;
            dp_ualign_d = accept & tgt[0];
            if (accept) dp_addr_d = tgt[30:1];
        end else begin
            dp_live_d = dp_live_q & ~flush;
        end

        // Redirects that cannot issue now are parked; a flush is never displaced by a pop.
        if (accept) begin
            pend_vld_d   = 1'b0;
            pend_flush_d = 1'b0;
        end else if (flush) begin
            pend_vld_d   = 1'b1;
            pend_flush_d = 1'b1;
            pend_addr_d  = s_flush_addr_i;
        end else if (pop && !(pend_vld_q && pend_flush_q)) begin
            pend_vld_d   = 1'b1;
            pend_flush_d = 1'b0;
            pend_addr_d  = s_ras_addr_i;
        end
    end

    always_ff @(posedge s_clk_i) begin
        if (!s_resetn_i) begin
            state_q      <= ST_BOOT;
            pc_q         <= BOOT_ADDR[31:2];
            dp_addr_q    <= '0;
            dp_ualign_q  <= 1'b0;
            dp_live_q    <= 1'b0;
            pend_vld_q   <= 1'b0;
            pend_flush_q <= 1'b0;
            pend_addr_q  <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            dp_addr_q    <= dp_addr_d;
            dp_ualign_q  <= dp_ualign_d;
            dp_live_q    <= dp_live_d;
            pend_vld_q   <= pend_vld_d;
            pend_flush_q <= pend_flush_d;
            pend_addr_q  <= pend_addr_d;
        end
    end

    assign s_haddr_o      = {tgt[30:1], 2'b00};
    assign s_htrans_o     = issue ? 2'b10 : 2'b00;
    assign s_fetch_addr_o = dp_addr_q;
    assign s_valid_o      = live & s_hready_i;
    assign s_ualign_o     = dp_ualign_q;
    assign s_ferr_o       = err;

endmodule

// File: tb/tb_fetch_addr_gen.sv
// Directed bench for fetch_addr_gen: boot, flush, RAS pop, stall, wait states, bus error, wrap, reset.
module tb_fetch_addr_gen;

    logic        clk = 1'b0;
    logic        resetn, flush, ifb_full, hready, hresp;
    logic [30:0] flush_addr, ras_addr;
    logic [1:0]  poped;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic [29:0] fetch_addr;
    logic        valid, ualign, ferr;

    int nchk = 0;
    int nerr = 0;

    fetch_addr_gen dut (
        .s_clk_i(clk), .s_resetn_i(resetn), .s_flush_i(flush), .s_flush_addr_i(flush_addr),
        .s_ras_poped_i(poped), .s_ras_addr_i(ras_addr), .s_ifb_full_i(ifb_full),
        .s_hready_i(hready), .s_hresp_i(hresp), .s_haddr_o(haddr), .s_htrans_o(htrans),
        .s_fetch_addr_o(fetch_addr), .s_valid_o(valid), .s_ualign_o(ualign), .s_ferr_o(ferr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn = 1'b0; flush = 1'b0; ifb_full = 1'b0; hready = 1'b1; hresp = 1'b0;
        flush_addr = '0; ras_addr = '0; poped = 2'b00;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_htrans", 32'(htrans), 32'h0);
        chk("rst_valid",  32'(valid),  32'h0);
        chk("rst_ualign", 32'(ualign), 32'h0);
        chk("rst_ferr",   32'(ferr),   32'h0);
        chk("rst_faddr",  32'(fetch_addr), 32'h0);
        chk("rst_haddr",  haddr, 32'h80);

        // boot and sequential fetch
        nxt(); resetn = 1'b1; #1;
        chk("boot_haddr",  haddr, 32'h80);
        chk("boot_htrans", 32'(htrans), 32'h2);
        chk("boot_valid",  32'(valid), 32'h0);
        nxt(); #1;
        chk("seq1_haddr", haddr, 32'h84);
        chk("seq1_valid", 32'(valid), 32'h1);
        chk("seq1_faddr", 32'(fetch_addr), 32'h20);
        nxt(); #1;
        chk("seq2_haddr", haddr, 32'h88);
        chk("seq2_faddr", 32'(fetch_addr), 32'h21);
        nxt(); nxt();

        // flush to odd halfword while 0x90 is in data phase
        nxt(); flush = 1'b1; flush_addr = 31'h0000_0101; #1;
        chk("fl_faddr", 32'(fetch_addr), 32'h24);
        chk("fl_haddr", haddr, 32'h200);
        chk("fl_kill",  32'(valid), 32'h0);
        nxt(); flush = 1'b0; #1;
        chk("fl_tgt_faddr",  32'(fetch_addr), 32'h80);
        chk("fl_tgt_ualign", 32'(ualign), 32'h1);
        chk("fl_tgt_valid",  32'(valid), 32'h1);
        chk("fl_next_haddr", haddr, 32'h204);

        // RAS pop
        nxt(); poped = 2'b01; ras_addr = 31'h0000_0400; #1;
        chk("pop_ualign0", 32'(ualign), 32'h0);
        chk("pop_haddr",   haddr, 32'h800);
        chk("pop_kill",    32'(valid), 32'h0);

        // flush and pop together: flush wins
        nxt(); flush = 1'b1; flush_addr = 31'h0000_0600; #1;
        chk("flpop_haddr", haddr, 32'hC00);
        chk("flpop_kill",  32'(valid), 32'h0);

        // fetch buffer backpressure for 3 cycles
        nxt(); flush = 1'b0; poped = 2'b00; ifb_full = 1'b1; #1;
        chk("st0_faddr",  32'(fetch_addr), 32'h300);
        chk("st0_valid",  32'(valid), 32'h1);
        chk("st0_htrans", 32'(htrans), 32'h0);
        nxt(); #1;
        chk("st1_htrans", 32'(htrans), 32'h0);
        chk("st1_valid",  32'(valid), 32'h0);
        nxt(); #1;
        chk("st2_htrans", 32'(htrans), 32'h0);
        nxt(); ifb_full = 1'b0; #1;
        chk("st_res_htrans", 32'(htrans), 32'h2);
        chk("st_res_haddr",  haddr, 32'hC04);

        // wait states with a pop in the first wait cycle
        nxt(); hready = 1'b0; poped = 2'b01; ras_addr = 31'h0000_1000; #1;
        chk("ws0_haddr",  haddr, 32'hC08);
        chk("ws0_htrans", 32'(htrans), 32'h2);
        chk("ws0_valid",  32'(valid), 32'h0);
        nxt(); poped = 2'b00; #1;
        chk("ws1_haddr",  haddr, 32'hC08);
        chk("ws1_htrans", 32'(htrans), 32'h2);
        nxt(); hready = 1'b1; #1;
        chk("ws_pend_haddr",  haddr, 32'h2000);
        chk("ws_pend_htrans", 32'(htrans), 32'h2);

        // bus error on a live beat
        nxt(); hresp = 1'b1; #1;
        chk("err_ferr",  32'(ferr), 32'h1);
        chk("err_faddr", 32'(fetch_addr), 32'h800);
`ifdef OPTION_FETCH_ERR_HALT_EN
        chk("err_htrans", 32'(htrans), 32'h0);
        nxt(); hresp = 1'b0; #1;
        chk("halt_htrans", 32'(htrans), 32'h0);
        chk("halt_valid",  32'(valid), 32'h0);
`else
        chk("err_htrans", 32'(htrans), 32'h2);
        chk("err_haddr",  haddr, 32'h2004);
        nxt(); hresp = 1'b0; #1;
        chk("post_err_haddr", haddr, 32'h2008);
        chk("post_err_faddr", 32'(fetch_addr), 32'h801);
`endif
        chk("post_err_ferr", 32'(ferr), 32'h0);

        // wrap at the top of the address space
        nxt(); flush = 1'b1; flush_addr = 31'h7FFF_FFFE; #1;
        chk("wrap_haddr",  haddr, 32'hFFFF_FFFC);
        chk("wrap_htrans", 32'(htrans), 32'h2);
        nxt(); flush = 1'b0; #1;
        chk("wrap_next_haddr", haddr, 32'h0);
        chk("wrap_faddr",      32'(fetch_addr), 32'h3FFF_FFFF);
        chk("wrap_valid",      32'(valid), 32'h1);

        // reset in the middle of fetching
        nxt(); resetn = 1'b0;
        nxt(); #1;
        chk("mrst_htrans", 32'(htrans), 32'h0);
        chk("mrst_valid",  32'(valid), 32'h0);
        chk("mrst_faddr",  32'(fetch_addr), 32'h0);
        chk("mrst_haddr",  haddr, 32'h80);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
